instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 30 +++
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit_fetch_buffer.sv | 84 ++++++++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// RV32 opcode constants and the fetch FSM state encoding.
package instruction_fetch_unit_pkg;

  localparam int XLEN     = 32;
  localparam int ILEN     = 32;
  localparam int OPCODE_W = 7;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [OPCODE_W-1:0] R_Type        = 7'b0110011;
  localparam logic [OPCODE_W-1:0] I_Type_LOGIC  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] I_Type_MEMORY = 7'b0000011;
  localparam logic [OPCODE_W-1:0] U_Type        = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [ILEN-1:0] inst);
    return inst[OPCODE_W-1:0];
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: redirect input, instruction memory port and the
// decode-facing instruction stream.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic                Redirect_i;
  logic [XLEN-1:0]     Redirect_PC_i;
  logic                IMem_Req_o;
  logic [XLEN-1:0]     IMem_Addr_o;
  logic                IMem_Ack_i;
  logic [ILEN-1:0]     IMem_Data_i;
  logic                Inst_Valid_o;
  logic                Inst_Ready_i;
  logic [ILEN-1:0]     Inst_o;
  logic [XLEN-1:0]     Inst_PC_o;
  logic [OPCODE_W-1:0] OP_o;

  modport master (
    input  Redirect_i, Redirect_PC_i, IMem_Ack_i, IMem_Data_i, Inst_Ready_i,
    output IMem_Req_o, IMem_Addr_o, Inst_Valid_o, Inst_o, Inst_PC_o, OP_o
  );

  modport slave (
    output Redirect_i, Redirect_PC_i, IMem_Ack_i, IMem_Data_i, Inst_Ready_i,
    input  IMem_Req_o, IMem_Addr_o, Inst_Valid_o, Inst_o, Inst_PC_o, OP_o
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// DEPTH-entry FIFO of {pc, instruction}; head is read straight from the
// storage flops so a pushed word is visible the cycle after the push.
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [XLEN-1:0]         push_pc,
  input  logic [ILEN-1:0]         push_inst,
  output logic [XLEN-1:0]         head_pc,
  output logic [ILEN-1:0]         head_inst,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] pc_mem_d   [DEPTH];
  logic [ILEN-1:0] inst_mem_q [DEPTH];
  logic [ILEN-1:0] inst_mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign head_inst = inst_mem_q[rd_ptr_q];

  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    do_pop     = pop && !empty;
    // at full a push only lands when the head leaves in the same cycle
    do_push    = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        pc_mem_d[wr_ptr_q]   = push_pc;
        inst_mem_d[wr_ptr_q] = push_inst;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small
// instruction buffer, with redirect flush.
//
//   state   | meaning
//   IDLE    | no request outstanding
//   WAIT    | request outstanding, returned word will be buffered
//   DROP    | request outstanding, returned word discarded (redirected)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            push, pop, flush, want_issue;
  logic            full, empty;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_inst;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    want_issue = 1'b0;
    pop        = !empty && bus.Inst_Ready_i && !bus.Redirect_i;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Redirect_i) begin
          flush = 1'b1;
          pc_d  = word_align(bus.Redirect_PC_i);
        end else begin
          want_issue = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.Redirect_i) begin
          flush   = 1'b1;
          pc_d    = word_align(bus.Redirect_PC_i);
          state_d = bus.IMem_Ack_i ? ST_IDLE : ST_DROP;
        end else if (bus.IMem_Ack_i) begin
          push       = !full || pop;
          pc_d       = pc_q + XLEN'(4);
          state_d    = ST_IDLE;
          want_issue = 1'b1;
        end
      end
      ST_DROP: begin
        if (bus.Redirect_i) begin
          flush = 1'b1;
          pc_d  = word_align(bus.Redirect_PC_i);
        end
        if (bus.IMem_Ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // occupancy after this cycle's push/pop; nothing is outstanding once we get here
    occ = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    if (want_issue && (occ < (CW+1)'(BUF_DEPTH))) begin
      state_d = ST_WAIT;
      addr_d  = pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_pc   (pc_q),
    .push_inst (bus.IMem_Data_i),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.IMem_Req_o   = (state_q != ST_IDLE);
  assign bus.IMem_Addr_o  = addr_q;
  assign bus.Inst_Valid_o = !empty;
  assign bus.Inst_o       = head_inst;
  assign bus.Inst_PC_o    = head_pc;
  assign bus.OP_o         = opcode_of(head_inst);

endmodule
